sap_out_uart_tx: RTL and testbench
==================================

Name: sap_out_uart_tx

Overview:
- Downstream consumer of the SAP-1 computer's 8-bit output register (SAP_out).
- Captures each value the SAP core writes to its output port into a small FIFO.
- Serializes the captured values as 8N1 UART frames, so program results can be observed on a single pin or a bench monitor.
- Sits beside SAPone in the top level and shares its clk and clr_.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per UART bit; legal values are 2 or more.
- FIFO_DEPTH, 4: number of capture entries; must be a power of 2, 2 or more.

Ports:
- clk  input  1  system clock; all logic acts on the rising edge.
- clr_  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- sap_out  input  8  SAP output register value.
- out_load  input  1  high for one or more cycles when the SAP output register loads (Lo control bit); each high cycle is one capture request.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high when a frame is in flight or the FIFO is non-empty.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of entries currently held.

Behaviour:
Reset
- Reset (clr_=0 at a rising edge): tx=1, busy=0, overflow=0, fifo_count=0, FIFO pointers=0, state=IDLE, bit and cycle counters=0.
- Reset has priority over every other event.
- Reset mid-frame aborts the frame; tx=1 from that edge onward. No partial-frame recovery.

Capture (push)
- On each edge with out_load=1, sap_out is written at the write pointer.
- The push is accepted if fifo_count<FIFO_DEPTH, or if a pop happens on the same edge.
- Push while full with no pop: the data is dropped, overflow is set to 1, and overflow stays 1 until reset.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop on the same edge leave fifo_count unchanged.

Transmit state machine (all outputs are registered)
- IDLE:
  - tx=1.
  - If fifo_count>0: pop the head into the shift register, set tx=0, cycle counter=0, and go to START.
  - The first start-bit cycle is the cycle after the edge at which IDLE sees fifo_count>0.
- START:
  - Hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - tx takes data bit 0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After bit 7, go to STOP with tx=1.
- STOP:
  - Hold tx=1 for CLKS_PER_BIT cycles.
  - On the last stop-bit edge, if fifo_count>0, pop and enter START directly, with no idle gap. Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.

Other rules
- busy = (state!=IDLE) or (fifo_count!=0).
- busy is driven combinationally from registers only, with no input-to-output paths.
- sap_out is sampled only on out_load cycles; changes at other times are ignored.
- Pop happens only at the IDLE→START or STOP→START transitions.

Test Plan:
1. Single byte:
   - Stimulus: reset 2 cycles, then one out_load with sap_out=8'hA5.
   - Response: the tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide, 40 cycles total.
   - Response: busy falls in the cycle after the stop bit ends; fifo_count peaks at 1; overflow=0.
2. Back-to-back:
   - Stimulus: out_load on 3 consecutive cycles with values 8'h01, 8'h02, 8'h03.
   - Response: three contiguous frames, 120 cycles, with no idle-high gap between the stop bit and the next start bit.
   - Response: fifo_count sequence is 1,1,2, then decrements at each frame boundary.
3. Overflow:
   - Stimulus: out_load on 6 consecutive cycles with values 8'h10..8'h15, FIFO_DEPTH=4.
   - Response: 8'h10..8'h14 are transmitted in order and 8'h15 is dropped.
   - Response: overflow rises on the 6th edge and stays 1 after the FIFO drains.
4. Full with simultaneous pop:
   - Stimulus: fill the FIFO to 4 during a frame, then assert out_load on the edge where STOP→START pops.
   - Response: the push is accepted, fifo_count stays 4, overflow stays 0.
5. Reset mid-frame:
   - Stimulus: assert clr_=0 during data bit 3 of frame 8'h00.
   - Response: at that edge tx=1, fifo_count=0, busy=0, overflow=0.
   - Response: after clr_=1 with no out_load, tx stays high for 50 cycles.
6. Pulse width:
   - Stimulus: CLKS_PER_BIT=7, send 8'hFF.
   - Response: start bit low for exactly 7 cycles, then tx high for 63 cycles.

Source files
------------

// File: rtl/sap_out_uart_tx.sv
// Captures SAP-1 output register loads into a small FIFO and serializes them
// as 8N1 UART frames on a single idle-high line.
module sap_out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               clr_,
  input  logic [7:0]                         sap_out,
  input  logic                               out_load,
  output logic                               tx,
  output logic                               busy,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CYW = $clog2(CLKS_PER_BIT);
  localparam logic [CYW-1:0] CYC_LAST   = CYW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         state;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [7:0]     shift;
  logic [2:0]     bit_idx;
  logic [CYW-1:0] cyc;
  logic           bit_end;
  logic           pop;
  logic           push;

  // Pop looks only at the registered count, so a same-edge push into an
  // empty FIFO is not transmitted until the following edge.
  always_comb begin
    bit_end = (cyc == CYC_LAST);
    pop     = (fifo_count != '0) &&
              ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    push    = out_load && ((fifo_count != COUNT_FULL) || pop);
    busy    = (state != S_IDLE) || (fifo_count != '0);
  end

  always_ff @(posedge clk) begin
    if (clr_ && push) begin
      mem[wr_ptr] <= sap_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (out_load && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      cyc     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            cyc   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cyc <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_out_uart_tx.sv
// Scoreboard bench for sap_out_uart_tx: a queue-level model predicts accepted
// bytes and occupancy; a tx monitor decodes frames and checks them in order.
module tb_sap_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          clr_;
  logic          out_load;
  logic [7:0]    sap_out;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  logic          load7;
  logic [7:0]    d7;
  logic          tx7;
  logic          busy7;
  logic          overflow7;
  logic [1:0]    count7;

  always #5 clk = ~clk;

  sap_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .clr_(clr_), .sap_out(sap_out), .out_load(out_load),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  sap_out_uart_tx #(.CLKS_PER_BIT(7), .FIFO_DEPTH(2)) u_dut7 (
    .clk(clk), .clr_(clr_), .sap_out(d7), .out_load(load7),
    .tx(tx7), .busy(busy7), .overflow(overflow7), .fifo_count(count7)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents, transmitter free time, sticky overflow.
  byte unsigned mq[$];
  byte unsigned exp_q[$];
  int           k = 0;
  int           frame_end = 0;
  bit           m_ovf = 1'b0;
  bit           rst_flag = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, k, act, req);
    end
  endtask

  // The transmitter can take a byte at or after the edge where the previous
  // frame's last stop-bit cycle ends; pushes see the FIFO after that pop.
  task automatic model_edge(input logic r, input logic ld, input byte unsigned d);
    if (!r) begin
      mq.delete();
      exp_q.delete();
      m_ovf     = 1'b0;
      frame_end = 0;
      rst_flag  = 1'b1;
    end else begin
      if (mq.size() > 0 && k >= frame_end) begin
        exp_q.push_back(mq.pop_front());
        frame_end = k + FRAME;
      end
      if (ld) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic ld, input byte unsigned d);
    clr_     = r;
    out_load = ld;
    sap_out  = d;
    @(posedge clk);
    k++;
    model_edge(r, ld, d);
    @(negedge clk);
    check("fifo_count", int'(fifo_count), mq.size());
    check("busy", int'(busy), int'((k < frame_end) || (mq.size() != 0)));
    check("overflow", int'(overflow), int'(m_ovf));
    #1;
  endtask

  // Monitor: decodes each frame bit-by-bit against the scoreboard head.
  bit         in_frame = 1'b0;
  int         mcnt = 0;
  int         bad = 0;
  logic [9:0] fw;
  byte unsigned cur;

  always @(negedge clk) begin
    if (rst_flag) begin
      rst_flag = 1'b0;
      in_frame = 1'b0;
    end
    if (!in_frame && tx !== 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start at edge %0d: tx=%b required=1", k, tx);
      end else begin
        cur      = exp_q.pop_front();
        fw       = {1'b1, cur, 1'b0};
        in_frame = 1'b1;
        mcnt     = 0;
        bad      = 0;
      end
    end
    if (in_frame) begin
      if (tx !== fw[mcnt / CPB]) bad++;
      mcnt++;
      if (mcnt == FRAME) begin
        in_frame = 1'b0;
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL frame_%02h: %0d of %0d bit-cycles wrong, required frame bits %b",
                   cur, bad, FRAME, fw);
        end
      end
    end
  end

  int zeros;
  int ones;
  int busy_n;
  int phase;
  int rate;

  initial begin
    load7 = 1'b0;
    d7    = 8'h00;

    // Reset state
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("reset_tx", int'(tx), 1);
    check("reset_tx7", int'(tx7), 1);

    // Single byte
    step(1'b1, 1'b1, 8'hA5);
    repeat (45) step(1'b1, 1'b0, 8'h00);

    // Back-to-back
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    repeat (125) step(1'b1, 1'b0, 8'h00);

    // Overflow: sixth capture dropped, flag sticky
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(8'h10 + i));
    repeat (250) step(1'b1, 1'b0, 8'h00);
    check("overflow_sticky", int'(overflow), 1);

    // Full FIFO with simultaneous STOP->START pop
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h20 + i));
    repeat (36) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h25);
    check("full_pop_count", int'(fifo_count), 4);
    check("full_pop_ovf", int'(overflow), 0);
    repeat (220) step(1'b1, 1'b0, 8'h00);

    // Reset during data bit 3 of 8'h00
    step(1'b1, 1'b1, 8'h00);
    repeat (17) step(1'b1, 1'b0, 8'h00);
    check("pre_reset_tx_low", int'(tx), 0);
    step(1'b0, 1'b0, 8'h00);
    check("midreset_tx", int'(tx), 1);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b0, 8'h00);
      check("post_reset_idle_tx", int'(tx), 1);
    end

    // Randomized traffic with varying load density and rare resets
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) rate = $urandom_range(0, 4);
      phase = $urandom_range(0, 3);
      if ($urandom_range(0, 599) == 0) step(1'b0, 1'b0, 8'h00);
      else step(1'b1, (phase < rate), 8'($urandom_range(0, 255)));
    end

    // Drain, bounded
    for (int i = 0; i < 400 && (mq.size() != 0 || k < frame_end + 2); i++)
      step(1'b1, 1'b0, 8'h00);
    check("drain_scoreboard_empty", exp_q.size(), 0);
    check("drain_monitor_idle", int'(in_frame), 0);
    check("drain_tx_idle", int'(tx), 1);

    // Seven-cycle bit width on the second instance
    zeros  = 0;
    ones   = 0;
    busy_n = 0;
    load7  = 1'b1;
    d7     = 8'hFF;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0, 8'h00);
      load7 = 1'b0;
      if (busy7) busy_n++;
      if (tx7 == 1'b0) zeros++;
      else if (zeros > 0) ones++;
    end
    check("cpb7_start_width", zeros, 7);
    check("cpb7_high_after_start", ones, 72);
    check("cpb7_busy_cycles", busy_n, 71);
    check("cpb7_count", int'(count7), 0);
    check("cpb7_overflow", int'(overflow7), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
